// File: rtl/pe_pkg.sv
// Shared types and default sizing for the pe_typeb processing element.
package pe_pkg;

  localparam int DWIDTH_DEF  = 32;
  localparam int LATENCY_DEF = 6;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } op_e;

endpackage

// File: rtl/pe_pipe_stage.sv
// One enable-gated pipeline register carrying valid, op, last and result data.
module pe_pipe_stage
  import pe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  op_e              i_op,
  input  logic             i_last,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output op_e              o_op,
  output logic             o_last,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  op_e              r_op;
  logic             r_last;
  logic [WIDTH-1:0] r_data;

  // Advance the stage only when enabled; hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_op    <= OP_ADD;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_op    <= i_op;
      r_last  <= i_last;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/pe_typeb.sv
// Pipelined signed ADD/SUB/MUL/MAC element with valid/ready handshakes.
// The arithmetic result is formed at the input, carried through LATENCY-1
// stages, and the final output register folds MAC beats into the accumulator
// so bursts stream at one beat per cycle.
module pe_typeb
  import pe_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DWIDTH-1:0]   inp1,
  input  logic [DWIDTH-1:0]   inp2,
  input  logic                t_valid_inp1,
  input  logic                t_valid_inp2,
  output logic                t_ready_inp1,
  output logic                t_ready_inp2,
  input  logic                t_last_inp,
  input  logic [1:0]          op,
  output logic [2*DWIDTH-1:0] out1,
  output logic                t_valid_out1,
  input  logic                t_ready_out1
);

  localparam int RW = 2 * DWIDTH;

  logic          w_stall;
  logic          w_fire;
  logic [RW-1:0] w_a;
  logic [RW-1:0] w_b;
  logic [RW-1:0] w_result;

  logic          w_valid [LATENCY];
  op_e           w_op    [LATENCY];
  logic          w_last  [LATENCY];
  logic [RW-1:0] w_data  [LATENCY];

  logic [RW-1:0] r_out;
  logic          r_vout;
  logic [RW-1:0] r_acc;

  assign w_stall      = r_vout & ~t_ready_out1;
  assign w_fire       = t_valid_inp1 & t_valid_inp2 & ~w_stall;
  assign t_ready_inp1 = ~w_stall;
  assign t_ready_inp2 = ~w_stall;

  // Sign-extend to the result width; the low RW bits of the product of the
  // extended operands equal the exact signed DWIDTH x DWIDTH product.
  assign w_a = {{DWIDTH{inp1[DWIDTH-1]}}, inp1};
  assign w_b = {{DWIDTH{inp2[DWIDTH-1]}}, inp2};

  // Select the per-beat result; MAC beats carry their product.
  always_comb begin
    w_result = '0;
    case (op_e'(op))
      OP_ADD:  w_result = w_a + w_b;
      OP_SUB:  w_result = w_a - w_b;
      default: w_result = w_a * w_b;
    endcase
  end

  assign w_valid[0] = w_fire;
  assign w_op[0]    = op_e'(op);
  assign w_last[0]  = t_last_inp;
  assign w_data[0]  = w_result;

  generate
    for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : g_stage
      pe_pipe_stage #(.WIDTH(RW)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (~w_stall),
        .i_valid (w_valid[gi]),
        .i_op    (w_op[gi]),
        .i_last  (w_last[gi]),
        .i_data  (w_data[gi]),
        .o_valid (w_valid[gi+1]),
        .o_op    (w_op[gi+1]),
        .o_last  (w_last[gi+1]),
        .o_data  (w_data[gi+1])
      );
    end
  endgenerate

  // Output register and accumulator: MAC beats accumulate, the last beat
  // emits acc+product and clears; other ops pass straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_vout <= 1'b0;
      r_acc  <= '0;
    end else if (!w_stall) begin
      r_vout <= 1'b0;
      if (w_valid[LATENCY-1]) begin
        if (w_op[LATENCY-1] == OP_MAC) begin
          if (w_last[LATENCY-1]) begin
            r_out  <= r_acc + w_data[LATENCY-1];
            r_vout <= 1'b1;
            r_acc  <= '0;
          end else begin
            r_acc  <= r_acc + w_data[LATENCY-1];
          end
        end else begin
          r_out  <= w_data[LATENCY-1];
          r_vout <= 1'b1;
        end
      end
    end
  end

  assign out1         = r_out;
  assign t_valid_out1 = r_vout;

endmodule

// File: tb/tb_pe_typeb.sv
// Directed self-checking bench for pe_typeb (DWIDTH=32, LATENCY=6).
module tb_pe_typeb;
  import pe_pkg::*;

  localparam int DW  = 32;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] inp1, inp2;
  logic          t_valid_inp1, t_valid_inp2;
  logic          t_ready_inp1, t_ready_inp2;
  logic          t_last_inp;
  logic [1:0]    op;
  logic [2*DW-1:0] out1;
  logic          t_valid_out1;
  logic          t_ready_out1;

  pe_typeb #(.DWIDTH(DW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inp1         (inp1),
    .inp2         (inp2),
    .t_valid_inp1 (t_valid_inp1),
    .t_valid_inp2 (t_valid_inp2),
    .t_ready_inp1 (t_ready_inp1),
    .t_ready_inp2 (t_ready_inp2),
    .t_last_inp   (t_last_inp),
    .op           (op),
    .out1         (out1),
    .t_valid_out1 (t_valid_out1),
    .t_ready_out1 (t_ready_out1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int last_fire_cyc;

  logic [63:0] got_q[$];
  int          got_cyc[$];
  logic [63:0] exp_q[$];

  // Record every accepted result, away from the active edge.
  always @(negedge clk) begin
    if (t_valid_out1 && t_ready_out1) begin
      got_q.push_back(out1);
      got_cyc.push_back(cyc);
      $display("[%0d] out1=%h", cyc, out1);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Present one beat on both channels and hold it until transferred.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [1:0] o, input logic l);
    int   waited = 0;
    logic ok;
    inp1 = a; inp2 = b; op = o; t_last_inp = l;
    t_valid_inp1 = 1'b1; t_valid_inp2 = 1'b1;
    do begin
      @(negedge clk);
      ok = t_ready_inp1;
      last_fire_cyc = cyc;
      waited++;
      @(posedge clk); #1;
    end while (!ok && waited < 100);
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    $display("[%0d] send a=%h b=%h op=%0d last=%0d", last_fire_cyc, a, b, o, l);
    t_valid_inp1 = 1'b0; t_valid_inp2 = 1'b0; t_last_inp = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 6) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic compare_outs(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; t_ready_out1 = 1'b1;
    inp1 = 32'd1; inp2 = 32'd1; op = 2'b00; t_last_inp = 1'b0;
    t_valid_inp1 = 1'b1; t_valid_inp2 = 1'b1;   // valid during reset must not transfer
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(t_valid_out1), 64'd0);
    check("rst_out1", out1, 64'd0);
    check("rst_ready", 64'(t_ready_inp1), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; t_valid_inp1 = 1'b0; t_valid_inp2 = 1'b0;
    drain();
    compare_outs("rst_notransfer");

    // Single ADD and its latency
    send(32'd7, 32'hFFFF_FFFD, 2'b00, 1'b0);
    exp_q.push_back(64'd4);
    drain();
    if (got_cyc.size() > 0) check("add_latency", 64'(got_cyc[0] - last_fire_cyc), 64'(LAT));
    else check("add_latency", 64'd0, 64'(LAT));
    compare_outs("add");

    // Arithmetic corner cases, back-to-back
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b10, 1'b0); exp_q.push_back(64'h3FFF_FFFF_0000_0001);
    send(32'd0,         32'd1,         2'b01, 1'b0); exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    send(32'hFFFF_FFFE, 32'd3,         2'b10, 1'b0); exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b00, 1'b0); exp_q.push_back(64'h0000_0000_FFFF_FFFE);
    send(32'h8000_0000, 32'h8000_0000, 2'b00, 1'b0); exp_q.push_back(64'hFFFF_FFFF_0000_0000);
    send(32'h8000_0000, 32'h8000_0000, 2'b10, 1'b0); exp_q.push_back(64'h4000_0000_0000_0000);
    drain();
    compare_outs("arith");

    // MAC bursts, including pass-through ops inside a burst
    send(32'd2, 32'd3, 2'b11, 1'b0);
    send(32'd4, 32'd5, 2'b11, 1'b0);
    send(32'hFFFF_FFFF, 32'd6, 2'b11, 1'b1); exp_q.push_back(64'd20);
    send(32'd1, 32'd1, 2'b11, 1'b1);         exp_q.push_back(64'd1);
    send(32'd2, 32'd2, 2'b11, 1'b0);
    send(32'd1, 32'd1, 2'b00, 1'b0);         exp_q.push_back(64'd2);
    send(32'd3, 32'd3, 2'b11, 1'b1);         exp_q.push_back(64'd13);
    drain();
    compare_outs("mac");

    // Stream of ADDs with a 4-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(32'(i), 32'd100, 2'b00, 1'b0);
          exp_q.push_back(64'(i + 100));
        end
      end
      begin
        logic [63:0] held;
        repeat (8) @(posedge clk);
        #1 t_ready_out1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) held = out1;
          check("stall_ready", 64'(t_ready_inp1), 64'd0);
          check("stall_valid", 64'(t_valid_out1), 64'd1);
          check("stall_hold", out1, held);
        end
        @(posedge clk); #1 t_ready_out1 = 1'b1;
      end
    join
    drain();
    compare_outs("stream");

    // One channel valid alone must not transfer
    inp1 = 32'd5; inp2 = 32'd6; op = 2'b00; t_last_inp = 1'b0;
    t_valid_inp1 = 1'b1; t_valid_inp2 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    t_valid_inp2 = 1'b1;
    @(negedge clk); last_fire_cyc = cyc;
    @(posedge clk); #1;
    t_valid_inp1 = 1'b0; t_valid_inp2 = 1'b0;
    exp_q.push_back(64'd11);
    drain();
    if (got_cyc.size() > 0) check("pair_latency", 64'(got_cyc[0] - last_fire_cyc), 64'(LAT));
    else check("pair_latency", 64'd0, 64'(LAT));
    compare_outs("pair");

    // Reset in the middle of a MAC burst discards the partial sum
    send(32'd5, 32'd5, 2'b11, 1'b0);
    send(32'd7, 32'd7, 2'b11, 1'b0);
    repeat (LAT + 2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(t_valid_out1), 64'd0);
    check("midrst_out1", out1, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'd3, 32'd3, 2'b11, 1'b1); exp_q.push_back(64'd9);
    drain();
    compare_outs("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
